// File: rtl/gnn_input_loader.sv
// rtl/gnn_input_loader.sv - collects a 40-word operand stream into stable feature/weight buses
// Frames are held for the GNN top until all output-ready flags return, then a fixed gap re-opens the stream.
module gnn_input_loader #(
    parameter int DW          = 5,
    parameter int N_FEAT      = 16,
    parameter int N_WGT       = 24,
    parameter int HOLD_CYCLES = 5,
    parameter int TIMEOUT     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [DW-1:0]          s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [N_FEAT*DW-1:0]   x_flat,
    output logic [N_WGT*DW-1:0]    w_flat,
    output logic                   in_ready,
    input  logic [7:0]             out_rdy,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   timeout
);

    localparam int N_TOT = N_FEAT + N_WGT;
    localparam int IW    = $clog2(N_TOT);
    localparam int XW    = $clog2(N_FEAT);
    localparam int WW    = $clog2(N_WGT);
    localparam int TW    = $clog2(TIMEOUT);
    localparam int HW    = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ARMED = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_cnt;
    logic [HW-1:0]   r_hcnt;
    logic            r_in_ready;
    logic            r_frame_done;
    logic            r_frame_err;
    logic            r_timeout;
    logic [DW-1:0]   r_x [N_FEAT];
    logic [DW-1:0]   r_w [N_WGT];

    logic            w_accept;
    logic            w_store;
    logic            w_err;
    logic            w_done;
    logic            w_tmo;
    logic            w_at_end;
    logic            w_is_feat;
    logic [XW-1:0]   w_xi;
    logic [WW-1:0]   w_wi;

    assign w_at_end  = (r_idx == IW'(N_TOT - 1));
    assign w_is_feat = (r_idx < IW'(N_FEAT));
    assign w_xi      = XW'(r_idx);
    assign w_wi      = WW'(r_idx - IW'(N_FEAT));

    // Gated by rst_n so the port reads 0 for the whole time reset is held.
    assign s_ready    = rst_n && (r_state == S_LOAD);
    assign in_ready   = r_in_ready;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign timeout    = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_store     = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (s_valid) begin
                    w_accept = 1'b1;
                    if (s_last && w_at_end) begin
                        w_store     = 1'b1;
                        w_state_nxt = S_ARMED;
                    end else if (s_last || w_at_end) begin
                        w_err = 1'b1;
                    end else begin
                        w_store = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                // A full AND of the flags beats an expiring counter on the same edge.
                if (&out_rdy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_hcnt == HW'(HOLD_CYCLES - 1)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_err || (w_state_nxt == S_ARMED)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            r_cnt        <= (r_state == S_ARMED) ? r_cnt + 1'b1 : '0;
            r_hcnt       <= (r_state == S_DRAIN) ? r_hcnt + 1'b1 : '0;
            r_in_ready   <= (w_state_nxt == S_ARMED);
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
            r_timeout    <= w_tmo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_FEAT; i++) begin
                r_x[i] <= '0;
            end
            for (int i = 0; i < N_WGT; i++) begin
                r_w[i] <= '0;
            end
        end else if (w_store) begin
            if (w_is_feat) begin
                r_x[w_xi] <= s_data;
            end else begin
                r_w[w_wi] <= s_data;
            end
        end
    end

    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_x
        assign x_flat[gi*DW +: DW] = r_x[gi];
    end

    for (genvar gi = 0; gi < N_WGT; gi++) begin : g_w
        assign w_flat[gi*DW +: DW] = r_w[gi];
    end

endmodule

// File: tb/tb_gnn_input_loader.sv
// tb/tb_gnn_input_loader.sv - scoreboard bench for gnn_input_loader
module tb_gnn_input_loader;

    localparam int DW = 5;
    localparam int NF = 16;
    localparam int NW = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic [DW-1:0]     s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic [NF*DW-1:0]  x_flat;
    logic [NW*DW-1:0]  w_flat;
    logic              in_ready;
    logic [7:0]        out_rdy = 8'h00;
    logic              frame_done;
    logic              frame_err;
    logic              timeout;

    int total = 0;
    int bad   = 0;

    logic [NF*DW-1:0] exp_x_q[$];
    logic [NW*DW-1:0] exp_w_q[$];

    gnn_input_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .x_flat     (x_flat),
        .w_flat     (w_flat),
        .in_ready   (in_ready),
        .out_rdy    (out_rdy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit gap);
        int t;
        t = 0;
        if (gap) @(posedge clk);
        @(negedge clk);
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            total++;
            bad++;
            $display("FAIL send_ready_wait s_ready=%b required 1", s_ready);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Expected buses are built and queued before the words go out.
    task automatic send_frame(input int off, input int n_words, input int last_at, input bit half);
        logic [NF*DW-1:0] ex;
        logic [NW*DW-1:0] ew;
        logic [DW-1:0]    d;
        ex = '0;
        ew = '0;
        for (int k = 1; k <= n_words; k++) begin
            d = DW'(k + off);
            if (k <= NF) ex[(k-1)*DW +: DW] = d;
            else         ew[(k-1-NF)*DW +: DW] = d;
        end
        if (n_words == NF + NW && last_at == NF + NW) begin
            exp_x_q.push_back(ex);
            exp_w_q.push_back(ew);
        end
        for (int k = 1; k <= n_words; k++) begin
            send_word(DW'(k + off), (k == last_at), half && (k > 1));
        end
    endtask

    task automatic check_frame(input string name);
        logic [NF*DW-1:0] ex;
        logic [NW*DW-1:0] ew;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready got %b required 1", name, in_ready);
        end
        total++;
        if (exp_x_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty got 0 entries required 1", name);
        end else begin
            ex = exp_x_q.pop_front();
            ew = exp_w_q.pop_front();
            if (x_flat !== ex) begin
                bad++;
                $display("FAIL %s x_flat got %h required %h", name, x_flat, ex);
            end
            total++;
            if (w_flat !== ew) begin
                bad++;
                $display("FAIL %s w_flat got %h required %h", name, w_flat, ew);
            end
        end
    endtask

    task automatic release_frame(input string name);
        int t;
        t = 0;
        out_rdy = 8'hFF;
        while (!frame_done && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        out_rdy = 8'h00;
        total++;
        if (t >= 50) begin
            bad++;
            $display("FAIL %s release frame_done got 0 required 1", name);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (s_ready !== 1'b0 || in_ready !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got s_ready=%b in_ready=%b pulses=%b%b%b required all 0",
                     s_ready, in_ready, frame_done, frame_err, timeout);
        end
        total++;
        if (x_flat !== '0 || w_flat !== '0) begin
            bad++;
            $display("FAIL reset_buses got x=%h w=%h required 0", x_flat, w_flat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release s_ready got %b required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        send_frame(0, 40, 40, 1'b0);
        total++;
        if (x_flat[4:0] !== 5'd1 || w_flat[4:0] !== 5'd17) begin
            bad++;
            $display("FAIL basic_words x0 got %0d required 1, w04 got %0d required 17", x_flat[4:0], w_flat[4:0]);
        end
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_armed_sready got %b required 0", s_ready);
        end
        check_frame("basic");
    endtask

    task automatic test_done();
        int n;
        @(negedge clk);
        out_rdy = 8'h0F;
        @(posedge clk);
        #1;
        @(negedge clk);
        out_rdy = 8'hF7;
        @(posedge clk);
        #1;
        total++;
        if (frame_done !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL done_partial got frame_done=%b in_ready=%b required 0 1", frame_done, in_ready);
        end
        @(negedge clk);
        out_rdy = 8'hFF;
        @(posedge clk);
        #1;
        out_rdy = 8'h00;
        total++;
        if (frame_done !== 1'b1 || in_ready !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got frame_done=%b in_ready=%b s_ready=%b required 1 0 0",
                     frame_done, in_ready, s_ready);
        end
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                total++;
                if (frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL done_single_cycle frame_done got %b required 0", frame_done);
                end
            end
        end
        total++;
        if (n !== 5 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL drain_length got %0d cycles in_ready=%b required 5 cycles in_ready=0", n, in_ready);
        end
    endtask

    task automatic test_valid_toggle();
        send_frame(5, 40, 40, 1'b1);
        check_frame("valid_toggle");
    endtask

    task automatic test_timeout();
        int n;
        bit saw_done;
        bit early_drop;
        n = 0;
        saw_done = 0;
        early_drop = 0;
        out_rdy = 8'h7F;
        while (!timeout && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_done) saw_done = 1;
            if (n < 32 && !in_ready) early_drop = 1;
        end
        out_rdy = 8'h00;
        total++;
        if (n !== 32 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_cycle got %0d in_ready=%b required 32 in_ready=0", n, in_ready);
        end
        total++;
        if (saw_done || early_drop) begin
            bad++;
            $display("FAIL timeout_side got done=%b early_drop=%b required 0 0", saw_done, early_drop);
        end
    endtask

    task automatic test_done_vs_timeout();
        bit early;
        early = 0;
        send_frame(7, 40, 40, 1'b0);
        check_frame("done_vs_timeout");
        repeat (31) begin
            @(posedge clk);
            #1;
            if (frame_done || timeout) early = 1;
        end
        @(negedge clk);
        out_rdy = 8'hFF;
        @(posedge clk);
        #1;
        out_rdy = 8'h00;
        total++;
        if (frame_done !== 1'b1 || timeout !== 1'b0 || early) begin
            bad++;
            $display("FAIL done_beats_timeout got done=%b timeout=%b early=%b required 1 0 0",
                     frame_done, timeout, early);
        end
    endtask

    task automatic test_frame_err();
        send_frame(0, 10, 10, 1'b0);
        total++;
        if (frame_err !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL err_early_last got frame_err=%b in_ready=%b required 1 0", frame_err, in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL err_single_cycle frame_err got %b required 0", frame_err);
        end
        send_frame(2, 40, 0, 1'b0);
        total++;
        if (frame_err !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL err_missing_last got frame_err=%b in_ready=%b required 1 0", frame_err, in_ready);
        end
        send_frame(3, 40, 40, 1'b0);
        check_frame("after_err");
        release_frame("after_err");
    endtask

    task automatic test_reset_midframe();
        send_frame(4, 20, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (x_flat !== '0 || w_flat !== '0 || s_ready !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset got x=%h w=%h s_ready=%b in_ready=%b required 0",
                     x_flat, w_flat, s_ready, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(9, 40, 40, 1'b0);
        check_frame("after_reset");
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || x_flat !== '0) begin
            bad++;
            $display("FAIL armed_async_reset got in_ready=%b x=%h required 0 0", in_ready, x_flat);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        out_rdy = 8'hFF;
        send_frame(11, 40, 40, 1'b0);
        check_frame("b2b_first");
        send_frame(20, 40, 40, 1'b0);
        check_frame("b2b_second");
        release_frame("b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done();
        test_valid_toggle();
        test_timeout();
        test_done_vs_timeout();
        test_frame_err();
        test_reset_midframe();
        test_back_to_back();
        total++;
        if (exp_x_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", exp_x_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
